id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage feeding the ALU. Latches decoded operands, immediate, register numbers and control from decode; resolves data hazards by forwarding from EX/MEM and MEM/WB; detects load-use hazards and inserts a bubble while stalling fetch/decode; squashes the decode instruction on flush. Its combinational outputs drive the ALU's A, B and Alu_control directly, and the EX/MEM register downstream.

## Interface
- `W`, 32: datapath width
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-low reset
- `id_rs_data`, `id_rt_data`  in  W  register-file read data
- `id_imm`  in  W  sign-extended immediate
- `id_rs`, `id_rt`, `id_rd`  in  5  register numbers
- `id_uses_rs`, `id_uses_rt`  in  1  decode instruction actually reads rs / rt
- `id_alu_control`  in  4  ALU operation code (shared ALU codes)
- `id_alu_src`, `id_reg_dst`, `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg`  in  1  decode control
- `flush`  in  1  squash decode instruction (taken branch/jump)
- `exmem_reg_write`  in  1; `exmem_rd`  in  5; `exmem_result`  in  W  EX/MEM forwarding source
- `memwb_reg_write`  in  1; `memwb_rd`  in  5; `memwb_result`  in  W  MEM/WB forwarding source
- `stall`  out  1  hold PC and IF/ID this cycle
- `alu_a`, `alu_b`  out  W  ALU operands
- `alu_control`  out  4  ALU operation
- `store_data`  out  W  forwarded rt value for stores
- `ex_dest`  out  5  write register (rd if reg_dst else rt)
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`, `ex_valid`  out  1  control to EX/MEM

## Operation
- Registered state: rs/rt data, imm, rs, rt, rd, all control bits, `valid`.
- Per-edge update priority: `reset`=0 → clear all; else `flush` → load bubble; else load-use hazard → load bubble; else load decode fields, `valid`=1.
- Bubble: `valid`, reg_write, mem_read, mem_write, mem_to_reg = 0; data fields don't-care but cleared to 0 for determinism; alu_control = 0.
- Load-use hazard (combinational): `ex_valid & ex_mem_read & ex_dest!=0 & ((id_uses_rs & id_rs==ex_dest) | (id_uses_rt & id_rt==ex_dest))`.
- `stall` = hazard & ~flush & reset.
- Forwarding, per operand (rs and rt independently): if `exmem_reg_write & exmem_rd!=0 & exmem_rd==reg` → `exmem_result`; else if `memwb_reg_write & memwb_rd!=0 & memwb_rd==reg` → `memwb_result`; else latched register data. EX/MEM wins over MEM/WB. Register 0 is never forwarded.
- `alu_a` = forwarded rs; `store_data` = forwarded rt; `alu_b` = alu_src ? imm : forwarded rt.
- Control outputs are the latched fields gated by nothing further (bubble already zeroed them).
- No arithmetic beyond equality compares; all data W bits, no extension.

## Timing
- Decode→EX latency: 1 cycle. Forward muxes, `stall`, `ex_dest` combinational, same cycle.
- Reset (`reset`=0 at edge): every registered field 0; thus `alu_a`/`alu_b`/`store_data` = 0 unless forwarded, `alu_control`=0, all ex_* = 0, `ex_dest`=0; `stall`=0 while reset low.
- Load-use: exactly one bubble per hazard; on the following cycle EX holds the bubble, hazard deasserts, the held decode instruction loads and gets the load data via MEM/WB forwarding.
- Flush with hazard same cycle: bubble, `stall`=0.
- Reset mid-stall: reset wins, `stall` drops immediately.

## Structure
- ALU control codes and W default live in the shared parameters package, not redefined here.
- One sub-module: `forward_mux` (reg number, latched data, both forwarding sources → selected W-bit value), instantiated twice.

## Test plan
- Reset: hold `reset`=0 two cycles with nonzero decode inputs → all ex_* 0, `alu_control`=0, `stall`=0; release → next edge loads decode, `ex_valid`=1.
- Forwarding priority: EX rs=5, `exmem_rd`=5 result 0x11, `memwb_rd`=5 result 0x22 → `alu_a`=0x11; drop exmem_reg_write → 0x22; both rd=0 → latched data.
- Immediate select: alu_src=1, imm=0xFFFFFFFC, rt forwarded 0x33 → `alu_b`=0xFFFFFFFC, `store_data`=0x33.
- Load-use: lw to r8 in EX, decode reads r8 as rs → `stall`=1 one cycle, EX becomes bubble, then instruction issues with `memwb_result` forwarded; decode using r8 with uses_rs=0 → no stall.
- Flush vs hazard: hazard and `flush` same cycle → bubble loaded, `stall`=0.
- Register 0: EX/MEM writes r0 with 0xDEAD, EX reads r0 → `alu_a`=latched 0, no forwarding; lw to r0 → no stall.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared parameters for the ID/EX stage: default datapath width, ALU codes,
// the latched control bundle and the forwarding match helper.
package id_ex_stage_pkg;

    localparam int W_DEF = 32;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

    typedef struct packed {
        logic [3:0] alu_control;
        logic       alu_src;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       valid;
    } id_ex_ctrl_t;

    localparam id_ex_ctrl_t CTRL_BUBBLE = '0;

    // r0 is hardwired to zero, so a write to it is never a forwarding source
    function automatic logic fwd_hit(input logic       we,
                                     input logic [4:0] rd,
                                     input logic [4:0] r);
        return we && (rd != 5'd0) && (rd == r);
    endfunction

endpackage

// File: rtl/id_ex_stage_forward_mux.sv
// Operand forwarding select: EX/MEM result, then MEM/WB result,
// otherwise the register-file value latched in ID/EX.
module forward_mux
    import id_ex_stage_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [4:0]   reg_num,
    input  logic [W-1:0] reg_data,
    input  logic         exmem_reg_write,
    input  logic [4:0]   exmem_rd,
    input  logic [W-1:0] exmem_result,
    input  logic         memwb_reg_write,
    input  logic [4:0]   memwb_rd,
    input  logic [W-1:0] memwb_result,
    output logic [W-1:0] value
);

    always_comb begin
        value = reg_data;
        if (fwd_hit(exmem_reg_write, exmem_rd, reg_num))
            value = exmem_result;
        else if (fwd_hit(memwb_reg_write, memwb_rd, reg_num))
            value = memwb_result;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubble
// insertion and flush squashing; drives the ALU and EX/MEM directly.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] id_rs_data,
    input  logic [W-1:0] id_rt_data,
    input  logic [W-1:0] id_imm,
    input  logic [4:0]   id_rs,
    input  logic [4:0]   id_rt,
    input  logic [4:0]   id_rd,
    input  logic         id_uses_rs,
    input  logic         id_uses_rt,
    input  logic [3:0]   id_alu_control,
    input  logic         id_alu_src,
    input  logic         id_reg_dst,
    input  logic         id_reg_write,
    input  logic         id_mem_read,
    input  logic         id_mem_write,
    input  logic         id_mem_to_reg,
    input  logic         flush,
    input  logic         exmem_reg_write,
    input  logic [4:0]   exmem_rd,
    input  logic [W-1:0] exmem_result,
    input  logic         memwb_reg_write,
    input  logic [4:0]   memwb_rd,
    input  logic [W-1:0] memwb_result,
    output logic         stall,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [3:0]   alu_control,
    output logic [W-1:0] store_data,
    output logic [4:0]   ex_dest,
    output logic         ex_reg_write,
    output logic         ex_mem_read,
    output logic         ex_mem_write,
    output logic         ex_mem_to_reg,
    output logic         ex_valid
);

    logic [W-1:0] rs_data_q;
    logic [W-1:0] rt_data_q;
    logic [W-1:0] imm_q;
    logic [4:0]   rs_q;
    logic [4:0]   rt_q;
    logic [4:0]   rd_q;
    id_ex_ctrl_t  ctrl_q;
    id_ex_ctrl_t  id_ctrl;
    logic         hazard;
    logic [W-1:0] rs_fwd;
    logic [W-1:0] rt_fwd;

    always_comb begin
        id_ctrl             = CTRL_BUBBLE;
        id_ctrl.alu_control = id_alu_control;
        id_ctrl.alu_src     = id_alu_src;
        id_ctrl.reg_dst     = id_reg_dst;
        id_ctrl.reg_write   = id_reg_write;
        id_ctrl.mem_read    = id_mem_read;
        id_ctrl.mem_write   = id_mem_write;
        id_ctrl.mem_to_reg  = id_mem_to_reg;
        id_ctrl.valid       = 1'b1;
    end

    assign ex_dest = ctrl_q.reg_dst ? rd_q : rt_q;

    // A load in EX cannot forward yet: hold decode and bubble EX once
    assign hazard = ctrl_q.valid && ctrl_q.mem_read && (ex_dest != 5'd0)
                 && ((id_uses_rs && (id_rs == ex_dest))
                  || (id_uses_rt && (id_rt == ex_dest)));

    assign stall = hazard && !flush && reset;

    always_ff @(posedge clk) begin
        if (!reset || flush || hazard) begin
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            ctrl_q    <= CTRL_BUBBLE;
        end else begin
            rs_data_q <= id_rs_data;
            rt_data_q <= id_rt_data;
            imm_q     <= id_imm;
            rs_q      <= id_rs;
            rt_q      <= id_rt;
            rd_q      <= id_rd;
            ctrl_q    <= id_ctrl;
        end
    end

    forward_mux #(.W(W)) u_fwd_rs (
        .reg_num         (rs_q),
        .reg_data        (rs_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .value           (rs_fwd)
    );

    forward_mux #(.W(W)) u_fwd_rt (
        .reg_num         (rt_q),
        .reg_data        (rt_data_q),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .value           (rt_fwd)
    );

    assign alu_a         = rs_fwd;
    assign store_data    = rt_fwd;
    assign alu_b         = ctrl_q.alu_src ? imm_q : rt_fwd;
    assign alu_control   = ctrl_q.alu_control;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_valid      = ctrl_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding, immediate select,
// load-use bubble, flush priority, register 0 and reset during a stall.
module tb_id_ex_stage;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]   id_rs, id_rt, id_rd;
    logic         id_uses_rs, id_uses_rt;
    logic [3:0]   id_alu_control;
    logic         id_alu_src, id_reg_dst, id_reg_write;
    logic         id_mem_read, id_mem_write, id_mem_to_reg;
    logic         flush;
    logic         exmem_reg_write, memwb_reg_write;
    logic [4:0]   exmem_rd, memwb_rd;
    logic [W-1:0] exmem_result, memwb_result;
    logic         stall;
    logic [W-1:0] alu_a, alu_b, store_data;
    logic [3:0]   alu_control;
    logic [4:0]   ex_dest;
    logic         ex_reg_write, ex_mem_read, ex_mem_write;
    logic         ex_mem_to_reg, ex_valid;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.W(W)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs_data      (id_rs_data),
        .id_rt_data      (id_rt_data),
        .id_imm          (id_imm),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_rd           (id_rd),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .id_alu_control  (id_alu_control),
        .id_alu_src      (id_alu_src),
        .id_reg_dst      (id_reg_dst),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .id_mem_write    (id_mem_write),
        .id_mem_to_reg   (id_mem_to_reg),
        .flush           (flush),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .stall           (stall),
        .alu_a           (alu_a),
        .alu_b           (alu_b),
        .alu_control     (alu_control),
        .store_data      (store_data),
        .ex_dest         (ex_dest),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .ex_mem_to_reg   (ex_mem_to_reg),
        .ex_valid        (ex_valid)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic id_clear();
        id_rs_data = '0; id_rt_data = '0; id_imm = '0;
        id_rs = '0; id_rt = '0; id_rd = '0;
        id_uses_rs = 0; id_uses_rt = 0;
        id_alu_control = '0;
        id_alu_src = 0; id_reg_dst = 0; id_reg_write = 0;
        id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    endtask

    task automatic fwd_clear();
        exmem_reg_write = 0; exmem_rd = '0; exmem_result = '0;
        memwb_reg_write = 0; memwb_rd = '0; memwb_result = '0;
    endtask

    // lw r<rt>, 0(r2) placed in decode
    task automatic id_load(input logic [4:0] rt);
        id_clear();
        id_rs = 5'd2; id_rt = rt; id_uses_rs = 1;
        id_alu_control = 4'd2; id_alu_src = 1;
        id_reg_write = 1; id_mem_read = 1; id_mem_to_reg = 1;
    endtask

    task automatic test_reset();
        id_clear(); fwd_clear(); flush = 0;
        id_rs = 5'd3; id_rt = 5'd6; id_rd = 5'd4;
        id_rs_data = 32'hAAAA; id_rt_data = 32'hBBBB;
        id_alu_control = 4'd2; id_reg_dst = 1; id_reg_write = 1;
        id_mem_to_reg = 1; id_uses_rs = 1;
        reset = 0;
        step(); step();
        vectors++;
        if (ex_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b want 0", ex_valid);
        end
        vectors++;
        if ({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg} !== 4'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 0000",
                {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg});
        end
        vectors++;
        if (alu_control !== 4'd0) begin
            errors++; $display("FAIL reset_aluctl got %0d want 0", alu_control);
        end
        vectors++;
        if (ex_dest !== 5'd0 || alu_a !== 32'h0 || alu_b !== 32'h0) begin
            errors++; $display("FAIL reset_data got dest=%0d a=%h b=%h want 0",
                ex_dest, alu_a, alu_b);
        end
        vectors++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall got %b want 0", stall);
        end
        reset = 1;
        step();
        vectors++;
        if (ex_valid !== 1'b1 || ex_dest !== 5'd4 || alu_a !== 32'hAAAA
            || alu_control !== 4'd2 || ex_reg_write !== 1'b1) begin
            errors++; $display("FAIL reset_release got v=%b d=%0d a=%h c=%0d rw=%b want 1 4 aaaa 2 1",
                ex_valid, ex_dest, alu_a, alu_control, ex_reg_write);
        end
    endtask

    task automatic test_forwarding();
        id_clear(); fwd_clear();
        id_rs = 5'd5; id_rt = 5'd6; id_rd = 5'd7;
        id_rs_data = 32'h55; id_rt_data = 32'h66;
        id_reg_dst = 1; id_reg_write = 1; id_uses_rs = 1; id_uses_rt = 1;
        step();
        id_clear();
        exmem_reg_write = 1; exmem_rd = 5'd5; exmem_result = 32'h11;
        memwb_reg_write = 1; memwb_rd = 5'd5; memwb_result = 32'h22;
        #1;
        vectors++;
        if (alu_a !== 32'h11) begin
            errors++; $display("FAIL fwd_exmem_wins got %h want 11", alu_a);
        end
        vectors++;
        if (alu_b !== 32'h66) begin
            errors++; $display("FAIL fwd_rt_untouched got %h want 66", alu_b);
        end
        exmem_reg_write = 0;
        #1;
        vectors++;
        if (alu_a !== 32'h22) begin
            errors++; $display("FAIL fwd_memwb got %h want 22", alu_a);
        end
        exmem_reg_write = 1; exmem_rd = 5'd0; memwb_rd = 5'd0;
        #1;
        vectors++;
        if (alu_a !== 32'h55) begin
            errors++; $display("FAIL fwd_none got %h want 55", alu_a);
        end
        fwd_clear();
    endtask

    task automatic test_imm_select();
        id_clear(); fwd_clear();
        id_rs = 5'd1; id_rt = 5'd7; id_rt_data = 32'h77;
        id_imm = 32'hFFFF_FFFC; id_alu_src = 1; id_mem_write = 1;
        id_uses_rs = 1; id_uses_rt = 1;
        step();
        id_clear();
        exmem_reg_write = 1; exmem_rd = 5'd7; exmem_result = 32'h33;
        #1;
        vectors++;
        if (alu_b !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL imm_alu_b got %h want fffffffc", alu_b);
        end
        vectors++;
        if (store_data !== 32'h33 || ex_mem_write !== 1'b1) begin
            errors++; $display("FAIL imm_store got %h mw=%b want 33 1",
                store_data, ex_mem_write);
        end
        fwd_clear();
    endtask

    task automatic test_load_use();
        id_load(5'd8);
        fwd_clear();
        step();
        vectors++;
        if (ex_dest !== 5'd8 || ex_mem_read !== 1'b1) begin
            errors++; $display("FAIL lu_load_in_ex got d=%0d mr=%b want 8 1",
                ex_dest, ex_mem_read);
        end
        // add r10, r8, r9
        id_clear();
        id_rs = 5'd8; id_rt = 5'd9; id_rd = 5'd10;
        id_rs_data = 32'hBAD; id_rt_data = 32'h99;
        id_reg_dst = 1; id_reg_write = 1; id_uses_rs = 1; id_uses_rt = 1;
        #1;
        vectors++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL lu_stall got %b want 1", stall);
        end
        step();
        vectors++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL lu_bubble got v=%b rw=%b st=%b want 0 0 0",
                ex_valid, ex_reg_write, stall);
        end
        step();
        memwb_reg_write = 1; memwb_rd = 5'd8; memwb_result = 32'h1234;
        #1;
        vectors++;
        if (ex_valid !== 1'b1 || alu_a !== 32'h1234 || alu_b !== 32'h99
            || ex_dest !== 5'd10) begin
            errors++; $display("FAIL lu_issue got v=%b a=%h b=%h d=%0d want 1 1234 99 10",
                ex_valid, alu_a, alu_b, ex_dest);
        end
        fwd_clear();
        id_load(5'd8);
        step();
        id_clear();
        id_rs = 5'd8; id_rt = 5'd8; id_rd = 5'd3;
        #1;
        vectors++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL lu_unused_rs got %b want 0", stall);
        end
        id_uses_rt = 1;
        #1;
        vectors++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL lu_rt_hazard got %b want 1", stall);
        end
    endtask

    task automatic test_flush_hazard();
        // EX still holds lw r8 from the previous task
        id_clear();
        id_rs = 5'd8; id_uses_rs = 1; id_reg_write = 1; id_rd = 5'd4;
        id_reg_dst = 1;
        flush = 1;
        #1;
        vectors++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL flush_stall got %b want 0", stall);
        end
        step();
        flush = 0;
        #1;
        vectors++;
        if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || ex_reg_write !== 1'b0) begin
            errors++; $display("FAIL flush_bubble got v=%b mr=%b rw=%b want 0 0 0",
                ex_valid, ex_mem_read, ex_reg_write);
        end
    endtask

    task automatic test_reg_zero();
        id_clear(); fwd_clear();
        id_rs = 5'd0; id_uses_rs = 1; id_reg_write = 1;
        step();
        exmem_reg_write = 1; exmem_rd = 5'd0; exmem_result = 32'hDEAD;
        memwb_reg_write = 1; memwb_rd = 5'd0; memwb_result = 32'hBEEF;
        #1;
        vectors++;
        if (alu_a !== 32'h0) begin
            errors++; $display("FAIL r0_no_fwd got %h want 0", alu_a);
        end
        fwd_clear();
        id_load(5'd0);
        step();
        id_clear();
        id_rs = 5'd0; id_uses_rs = 1;
        #1;
        vectors++;
        if (stall !== 1'b0 || ex_mem_read !== 1'b1) begin
            errors++; $display("FAIL r0_load_no_stall got st=%b mr=%b want 0 1",
                stall, ex_mem_read);
        end
    endtask

    task automatic test_reset_mid_stall();
        id_load(5'd8);
        fwd_clear();
        step();
        id_clear();
        id_rs = 5'd8; id_uses_rs = 1;
        #1;
        vectors++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL rst_stall_pre got %b want 1", stall);
        end
        reset = 0;
        #1;
        vectors++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL rst_stall_drop got %b want 0", stall);
        end
        step();
        vectors++;
        if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || ex_dest !== 5'd0) begin
            errors++; $display("FAIL rst_stall_clear got v=%b mr=%b d=%0d want 0 0 0",
                ex_valid, ex_mem_read, ex_dest);
        end
        reset = 1;
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_imm_select();
        test_load_use();
        test_flush_hazard();
        test_reg_zero();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
